button_conditioner: RTL and testbench

//  Upstream front end for segment_driver_3. Turns N raw, bouncing, asynchronous push-button inputs into clean

---
 rtl/button_conditioner_pkg.sv | 16 +
 rtl/button_conditioner_channel.sv | 115 +++++++++++
 rtl/button_conditioner.sv | 45 ++++
 tb/tb_button_conditioner.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
`default_nettype none
// button_conditioner_pkg -- repeat-FSM state encoding and board defaults shared by the conditioner.
// Rev 1.0
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // 10 ms of stability at the 50 MHz board clock
  localparam int BOARD_DEBOUNCE_CYCLES = 500000;

endpackage
`default_nettype wire

// File: rtl/button_conditioner_channel.sv
`default_nettype none
// button_conditioner_channel -- one button: 2-FF sync, debounce, edge pulses, optional auto-repeat.
// Rev 1.0
module button_conditioner_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic async_nreset,
  input  logic pressed_raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic press
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W  = $clog2(RPT_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  logic              sync_meta;
  logic              sync_out;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  rpt_state_t        state;
  logic [RCNT_W-1:0] rcnt;

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= pressed_raw;
      sync_out  <= sync_meta;
    end
  end

  // True on the edge where a candidate level has been stable long enough
  assign accept = (sync_out != level) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_out == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_out;
        cnt   <= '0;
        rise  <= sync_out;
        fall  <= ~sync_out;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // An accepted release always wins over a coincident repeat terminal count
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state <= RPT_IDLE;
      rcnt  <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (accept && sync_out) begin
        press <= 1'b1;
        state <= REPEAT_EN ? RPT_DELAY : RPT_IDLE;
        rcnt  <= '0;
      end else if (accept) begin
        state <= RPT_IDLE;
        rcnt  <= '0;
      end else begin
        case (state)
          RPT_DELAY: begin
            if (rcnt == DELAY_LAST) begin
              press <= 1'b1;
              state <= RPT_REPEAT;
              rcnt  <= '0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          RPT_REPEAT: begin
            if (rcnt == PERIOD_LAST) begin
              press <= 1'b1;
              rcnt  <= '0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: begin
            state <= RPT_IDLE;
            rcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// button_conditioner -- N independent push-button channels: polarity normalisation plus per-channel conditioning.
// Rev 1.0
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                 clk,
  input  logic                 async_nreset,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_re,
  output logic [N_BUTTONS-1:0] btn_fe,
  output logic [N_BUTTONS-1:0] btn_press
);

  logic [N_BUTTONS-1:0] pressed_raw;

  assign pressed_raw = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    button_conditioner_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN != 0),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk          (clk),
      .async_nreset (async_nreset),
      .pressed_raw  (pressed_raw[i]),
      .level        (btn_level[i]),
      .rise         (btn_re[i]),
      .fall         (btn_fe[i]),
      .press        (btn_press[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// tb_button_conditioner -- directed self-checking bench, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Rev 1.0
module tb_button_conditioner;

  logic       clk          = 1'b0;
  logic       async_nreset = 1'b0;
  logic [1:0] btn_raw      = 2'b11;
  logic [1:0] btn_level;
  logic [1:0] btn_re;
  logic [1:0] btn_fe;
  logic [1:0] btn_press;

  int         total = 0;
  int         bad   = 0;
  int         re_cnt;
  int         re_at;
  int         first0;
  int         first1;
  logic [7:0] acc;
  logic       exp_p;

  button_conditioner #(
    .N_BUTTONS       (2),
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW      (1),
    .REPEAT_EN       (1),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk          (clk),
    .async_nreset (async_nreset),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .btn_re       (btn_re),
    .btn_fe       (btn_fe),
    .btn_press    (btn_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {btn_level, btn_re, btn_fe, btn_press};
  endfunction

  initial begin
    // Reset held with keys released
    repeat (5) tick();
    check("reset_outs", 32'(outs()), 0);
    async_nreset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_outs", 32'(outs()), 0);
    end

    // Clean press and release on channel 0
    btn_raw[0] = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i < 6) check("press_wait", 32'({btn_level, btn_re}), 0);
    end
    check("press_level", 32'(btn_level), 32'h1);
    check("press_re", 32'(btn_re), 32'h1);
    check("press_press", 32'(btn_press), 32'h1);
    tick();
    check("press_re_once", 32'(btn_re), 0);
    check("press_hold", 32'(btn_level), 32'h1);
    btn_raw[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i < 6) check("release_wait", 32'({btn_level, btn_fe, btn_press}), 32'h10);
    end
    check("release_fe", 32'(btn_fe), 32'h1);
    check("release_level", 32'(btn_level), 0);
    tick();
    check("release_fe_once", 32'(btn_fe), 0);
    repeat (5) tick();

    // Bouncing press: 0,1,0,1 then settle low
    btn_raw[0] = 1'b0; tick();
    btn_raw[0] = 1'b1; tick();
    btn_raw[0] = 1'b0; tick();
    btn_raw[0] = 1'b1; tick();
    btn_raw[0] = 1'b0;
    re_cnt = 0;
    re_at  = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (btn_re[0]) begin
        re_cnt++;
        re_at = i;
      end
    end
    check("bounce_re_count", 32'(re_cnt), 1);
    check("bounce_re_at", 32'(re_at), 6);
    check("bounce_level", 32'(btn_level), 32'h1);
    btn_raw[0] = 1'b1;
    repeat (10) tick();
    check("bounce_released", 32'(btn_level), 0);

    // 3-cycle glitch is one short of acceptance
    acc = '0;
    btn_raw[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      acc |= outs();
    end
    btn_raw[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      acc |= outs();
    end
    check("glitch_rejected", 32'(acc), 0);

    // Auto-repeat: press at +0, +10, +13, ... until the release is accepted
    btn_raw[0] = 1'b0;
    repeat (6) tick();
    check("rpt_re", 32'(btn_re), 32'h1);
    check("rpt_p0", 32'(btn_press), 32'h1);
    for (int off = 1; off < 46; off++) begin
      if (off == 30) btn_raw[0] = 1'b1;
      tick();
      exp_p = (off < 35) && (off >= 10) && (((off - 10) % 3) == 0);
      check("rpt_press", 32'(btn_press[0]), 32'(exp_p));
      check("rpt_fe", 32'(btn_fe[0]), 32'(off == 35));
    end
    repeat (5) tick();

    // Simultaneous presses
    btn_raw = 2'b00;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) check("sim_early", 32'(btn_re), 0);
    end
    check("sim_re", 32'(btn_re), 32'h3);
    btn_raw = 2'b11;
    repeat (15) tick();

    // Channel 1 bounces while channel 0 presses cleanly
    btn_raw = 2'b00;
    first0 = -1;
    first1 = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i <= 4) btn_raw[1] = ((i % 2) == 1);
      if (btn_re[0] && first0 < 0) first0 = i;
      if (btn_re[1] && first1 < 0) first1 = i;
    end
    check("indep_ch0_at", 32'(first0), 6);
    check("indep_ch1_at", 32'(first1), 10);
    btn_raw = 2'b11;
    repeat (15) tick();

    // Reset mid-DELAY with the key still held
    btn_raw[0] = 1'b0;
    repeat (6) tick();
    check("rst6_re", 32'(btn_re[0]), 1);
    repeat (3) tick();
    check("rst_mid_pre", 32'(btn_level), 32'h1);
    async_nreset = 1'b0;
    #1;
    check("rst_mid_outs", 32'(outs()), 0);
    repeat (2) tick();
    async_nreset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i < 6) check("rst_rel_wait", 32'(btn_re), 0);
    end
    check("rst_rel_re", 32'(btn_re), 32'h1);
    check("rst_rel_level", 32'(btn_level), 32'h1);
    check("rst_rel_press", 32'(btn_press), 32'h1);
    btn_raw[0] = 1'b1;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
